// File: rtl/mfp_fifo_rd_pkg.sv
// rtl/mfp_fifo_rd_pkg.sv - shared constants and helpers for the FIFO read-side stream block
package mfp_fifo_rd_pkg;

    localparam int SKID_DEPTH         = 2;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Beat counter width; a one-beat burst still gets a 1-bit counter.
    function automatic int beat_width(input int burst_len);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < burst_len) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mfp_skid_buf2.sv
// rtl/mfp_skid_buf2.sv - two-entry head/tail skid buffer with push, pop, clear and occupancy
module mfp_skid_buf2
    import mfp_fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    input  logic                  i_clear,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_valid,
    output logic [1:0]            o_occ
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [1:0]            r_occ;

    // Head is a register so the stream output never glitches mid-stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else if (i_clear) begin
            r_occ <= 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (i_push) begin
                        r_head <= i_data;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_push && i_pop) begin
                        r_head <= i_data;
                    end else if (i_push) begin
                        r_tail <= i_data;
                        r_occ  <= 2'd2;
                    end else if (i_pop) begin
                        r_occ <= 2'd0;
                    end
                end
                default: begin
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) begin
                            r_tail <= i_data;
                        end else begin
                            r_occ <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_valid = (r_occ != 2'd0);
    assign o_occ   = r_occ;

endmodule

// File: rtl/mfp_fifo_rd_stream.sv
// rtl/mfp_fifo_rd_stream.sv - FIFO read-side consumer with burst-framed stream output; optional OCOUNT via MFP_FIFO_RD_CNT_EN
module mfp_fifo_rd_stream
    import mfp_fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BURST_LEN  = 4
`ifdef MFP_FIFO_RD_CNT_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
)(
    input  logic                  HCLK,
    input  logic                  HRESETn,
    output logic                  REN,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  REMPTY,
    input  logic                  FLUSH,
    output logic [DATA_WIDTH-1:0] ODATA,
    output logic                  OVALID,
    input  logic                  OREADY,
    output logic                  OLAST
`ifdef MFP_FIFO_RD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  OCOUNT
`endif
);

    localparam int            BW        = beat_width(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic [1:0]    w_occ;
    logic [2:0]    w_credit_used;
    logic          w_pop;
    logic          w_push;
    logic          w_ren;
    logic          r_inflight;
    logic          r_drop;
    logic [BW-1:0] r_beat;

    assign w_pop         = OVALID && OREADY;
    assign w_credit_used = {1'b0, w_occ} + {2'b0, r_inflight};

    // A pop this cycle frees a slot, so OREADY feeds REN combinationally to keep one word per cycle.
    assign w_ren  = HRESETn && !REMPTY && !FLUSH &&
                    (w_credit_used < (3'(SKID_DEPTH) + {2'b0, w_pop}));
    assign w_push = r_inflight && !r_drop && !FLUSH;
    assign REN    = w_ren;

    mfp_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .i_clk   (HCLK),
        .i_rst_n (HRESETn),
        .i_push  (w_push),
        .i_data  (RDATA),
        .i_pop   (w_pop),
        .i_clear (FLUSH),
        .o_head  (ODATA),
        .o_valid (OVALID),
        .o_occ   (w_occ)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
            r_beat     <= '0;
        end else begin
            r_inflight <= w_ren;
            r_drop     <= FLUSH && r_inflight;
            if (FLUSH) begin
                r_beat <= '0;
            end else if (w_pop) begin
                r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + BW'(1);
            end
        end
    end

    assign OLAST = OVALID && (r_beat == LAST_BEAT);

`ifdef MFP_FIFO_RD_CNT_EN
    logic [CNT_WIDTH-1:0] r_count;

    // Counts every completed handshake, including one in a flush cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_count <= '0;
        end else if (w_pop) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign OCOUNT = r_count;
`endif

endmodule

// File: tb/tb_mfp_fifo_rd_stream.sv
// tb/tb_mfp_fifo_rd_stream.sv - scoreboard bench for mfp_fifo_rd_stream
module tb_mfp_fifo_rd_stream;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic        FLUSH   = 1'b0;
    logic        OREADY  = 1'b0;
    logic [31:0] RDATA   = '0;
    logic        REMPTY;
    logic        REN;
    logic        OVALID;
    logic        OLAST;
    logic [31:0] ODATA;
`ifdef MFP_FIFO_RD_CNT_EN
    logic [3:0]  OCOUNT;
`endif

    logic [31:0] mem [0:63];
    int          wp = 0;
    int          rp = 0;
    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    mfp_fifo_rd_stream #(
        .DATA_WIDTH (32),
        .BURST_LEN  (4)
`ifdef MFP_FIFO_RD_CNT_EN
        ,
        .CNT_WIDTH  (4)
`endif
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .REN     (REN),
        .RDATA   (RDATA),
        .REMPTY  (REMPTY),
        .FLUSH   (FLUSH),
        .ODATA   (ODATA),
        .OVALID  (OVALID),
        .OREADY  (OREADY),
        .OLAST   (OLAST)
`ifdef MFP_FIFO_RD_CNT_EN
        ,
        .OCOUNT  (OCOUNT)
`endif
    );

    always #5 HCLK = ~HCLK;

    // FIFO read-side model: data appears the cycle after REN is sampled.
    assign REMPTY = (rp == wp);
    always @(posedge HCLK) begin
        if (REN) begin
            RDATA <= mem[rp[5:0]];
            rp    <= rp + 1;
        end
    end

    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (int'(dut.w_occ) + int'(dut.r_inflight) > 2) begin
                n_err++;
                $display("FAIL credit occ+inflight actual=%0d required<=2",
                         int'(dut.w_occ) + int'(dut.r_inflight));
            end
            if (!OVALID && OLAST) begin
                n_err++;
                $display("FAIL olast_idle actual=1 required=0");
            end
            if (OVALID) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat_unexpected actual data=%h last=%b required none", ODATA, OLAST);
                end else begin
                    if (ODATA !== exp_q[0].d || OLAST !== exp_q[0].l) begin
                        n_err++;
                        $display("FAIL beat actual data=%h last=%b required data=%h last=%b",
                                 ODATA, OLAST, exp_q[0].d, exp_q[0].l);
                    end
                    if (OREADY) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge HCLK);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic load(input logic [31:0] w);
        mem[wp[5:0]] = w;
        wp = wp + 1;
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            at_neg();
            n++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout actual remaining=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        step();
    endtask

    initial begin
        // Reset then idle
        repeat (2) begin
            at_neg();
            chk1("rst_ren", REN, 1'b0);
            chk1("rst_ovalid", OVALID, 1'b0);
            chk1("rst_olast", OLAST, 1'b0);
            chk("rst_odata", ODATA, 32'h0);
        end
        step();
        HRESETn = 1'b1;
        repeat (3) begin
            at_neg();
            chk1("idle_ren", REN, 1'b0);
            chk1("idle_ovalid", OVALID, 1'b0);
            chk1("idle_olast", OLAST, 1'b0);
        end

        // Streaming with latency check
        step();
        OREADY = 1'b1;
        load(32'hAAAABBBB); expect_beat(32'hAAAABBBB, 1'b0);
        load(32'hBBBBCCCC); expect_beat(32'hBBBBCCCC, 1'b0);
        load(32'hCCCCDDDD); expect_beat(32'hCCCCDDDD, 1'b0);
        load(32'hCCCCEEEE); expect_beat(32'hCCCCEEEE, 1'b1);
        at_neg();
        chk1("t2_ren_first", REN, 1'b1);
        chk1("t2_ovalid_c0", OVALID, 1'b0);
        at_neg();
        chk1("t2_ovalid_c1", OVALID, 1'b0);
        at_neg();
        chk1("t2_ovalid_c2", OVALID, 1'b1);
        repeat (3) begin
            at_neg();
            chk1("t2_stream", OVALID, 1'b1);
        end
        drain(20);
        at_neg();
        chk1("t2_empty_ovalid", OVALID, 1'b0);
        chk1("t2_empty_ren", REN, 1'b0);

        // Backpressure for 5 cycles
        step();
        OREADY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            load(32'h3000_0000 + i);
            expect_beat(32'h3000_0000 + i, (i == 3));
        end
        repeat (3) at_neg();
        repeat (2) begin
            at_neg();
            chk1("t3_ren_stall", REN, 1'b0);
            chk1("t3_ovalid_stall", OVALID, 1'b1);
        end
        step();
        OREADY = 1'b1;
        drain(30);

        // Flush the cycle after REN; beat was left at 2
        step();
        load(32'hF000_0000);
        for (int i = 1; i < 5; i++) begin
            load(32'hF000_0000 + i);
            expect_beat(32'hF000_0000 + i, (i == 4));
        end
        at_neg();
        chk1("t4_ren", REN, 1'b1);
        step();
        FLUSH = 1'b1;
        at_neg();
        chk1("t4_ren_flush", REN, 1'b0);
        step();
        FLUSH = 1'b0;
        at_neg();
        chk1("t4_ovalid_post", OVALID, 1'b0);
        drain(30);

        // Held flush with a full buffer
        step();
        OREADY = 1'b0;
        load(32'h6000_0000);
        load(32'h6000_0001);
        load(32'h6000_0002);
        expect_beat(32'h6000_0000, 1'b0);
        repeat (4) at_neg();
        step();
        FLUSH = 1'b1;
        step();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk1("t5_held_ovalid", OVALID, 1'b0);
            chk1("t5_held_ren", REN, 1'b0);
            step();
        end
        FLUSH  = 1'b0;
        OREADY = 1'b1;
        expect_beat(32'h6000_0002, 1'b0);
        drain(20);

        // Idle flush restarts framing, then 9 words
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        for (int i = 0; i < 9; i++) begin
            load(32'h9000_0000 + i);
            expect_beat(32'h9000_0000 + i, (i == 3 || i == 7));
        end
        drain(40);

`ifdef MFP_FIFO_RD_CNT_EN
        HRESETn = 1'b0;
        step();
        chk("t7_ocount_rst", {28'b0, OCOUNT}, 32'd0);
        HRESETn = 1'b1;
        step();
        for (int i = 0; i < 17; i++) begin
            load(32'hC000_0000 + i);
            expect_beat(32'hC000_0000 + i, (i % 4 == 3));
        end
        drain(60);
        step();
        chk("t7_ocount_17", {28'b0, OCOUNT}, 32'd1);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        step();
        chk("t7_ocount_flush", {28'b0, OCOUNT}, 32'd1);
        HRESETn = 1'b0;
        #1;
        chk("t7_ocount_clear", {28'b0, OCOUNT}, 32'd0);
        step();
        HRESETn = 1'b1;
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mfp_fifo_rd_stream.md
Name: mfp_fifo_rd_stream

Overview:
Read-side consumer of the dual-clock FIFO (mfp_fifo_dc), running in the SDRAM/AHB read clock domain. It pops FIFO words via REN/RDATA/REMPTY, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and presents a valid/ready stream with burst framing (OLAST) to the downstream AHB read-data path. It sustains one word per cycle when the FIFO is non-empty and the consumer is ready.

Parameters:
DATA_WIDTH, 32, FIFO/stream word width
BURST_LEN, 4, beats per burst; OLAST marks beat BURST_LEN-1; legal range 1..256
CNT_WIDTH, 16, width of optional OCOUNT

Ports:
HCLK  in  1  block clock, same clock as the FIFO read side (RCLK)
HRESETn  in  1  asynchronous active-low reset
REN  out  1  FIFO read enable (to mfp_fifo_dc REN)
RDATA  in  DATA_WIDTH  FIFO read data, valid in the cycle after REN was sampled high
REMPTY  in  1  FIFO empty flag
FLUSH  in  1  synchronous abort: drop buffered/in-flight data, restart burst framing
ODATA  out  DATA_WIDTH  stream data
OVALID  out  1  stream valid
OREADY  in  1  stream ready
OLAST  out  1  last beat of current burst
OCOUNT  out  CNT_WIDTH  accepted-beat counter (only with MFP_FIFO_RD_CNT_EN)

Behaviour:
- State: buffer entries buf[0..1], occupancy occ (0..2), inflight flag, drop flag, beat counter beat (0..BURST_LEN-1).
- Reset (async, HRESETn low): occ=0, inflight=0, drop=0, beat=0; OVALID=0, OLAST=0, ODATA=0, REN=0 (REN gated low while HRESETn low).
- pop = OVALID && OREADY.
- REN = !REMPTY && !FLUSH && (occ + inflight - pop < 2). Combinational path OREADY->REN is intentional.
- inflight <= REN each edge. When inflight is high, RDATA is written into the buffer tail at the next edge unless drop is set.
- Latency: REN sampled at edge E0 -> OVALID high after edge E1. Steady state: one word per cycle.
- ODATA/OVALID come from the buffer head. They are registered, hold stable while OVALID && !OREADY, and never change mid-stall.
- Simultaneous capture and pop: head advances and tail is written in the same edge; occ stays unchanged.
- Overflow is impossible by credit; the bench asserts occ+inflight <= 2.
- Burst: beat increments on pop and wraps to 0 after BURST_LEN-1. OLAST = OVALID && (beat == BURST_LEN-1). For BURST_LEN=1, OLAST = OVALID.
- FLUSH (sampled at edge):
  - occ <= 0 and beat <= 0.
  - drop <= inflight, so a word returning from a REN issued in the flush cycle or the previous cycle is discarded. drop clears after one capture slot.
  - REN is low during FLUSH.
  - A pop in the FLUSH cycle completes for the consumer. Framing still restarts at beat 0.
- REMPTY asserting while inflight is set: the in-flight word is still captured; no further REN is issued.
- Held FLUSH: output stays empty and REN stays low for the whole duration.

Optional Feature:
MFP_FIFO_RD_CNT_EN
- Defined: OCOUNT port exists. It counts pops, wraps at 2^CNT_WIDTH, resets to 0 on HRESETn, and is not cleared by FLUSH.
- Undefined: OCOUNT port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package/header mfp_fifo_rd_pkg:
  - skid depth constant (2)
  - beat-counter width function clog2(BURST_LEN)
  - default DATA_WIDTH
- One natural sub-module, mfp_skid_buf2: 2-entry head/tail buffer with push/pop/clear and occupancy. Credit logic, drop logic and framing stay in the top.

Test Plan:
1. Reset-then-idle: REMPTY=1, HRESETn low 2 cycles then high -> REN=0, OVALID=0, OLAST=0 throughout.
2. Streaming: FIFO preloaded AAAABBBB, BBBBCCCC, CCCCDDDD, CCCCEEEE; OREADY=1 -> four consecutive OVALID beats in that order; OLAST only on CCCCEEEE (BURST_LEN=4); first OVALID two edges after first REN.
3. Backpressure: OREADY=0 for 5 cycles mid-stream -> ODATA held stable, REN stops once occ+inflight=2, no word lost or duplicated after OREADY returns.
4. Flush with in-flight word: assert FLUSH for 1 cycle the cycle after REN -> returned word dropped, OVALID=0 next cycle, next accepted beat is the following FIFO word with beat=0.
5. Wrap/framing: 9 words with BURST_LEN=4 -> OLAST on beats 4 and 8; beat counter back at 0 after the 8th; 9th word has OLAST=0.
6. With MFP_FIFO_RD_CNT_EN and CNT_WIDTH=4: 17 pops -> OCOUNT=1; FLUSH does not clear it; HRESETn low clears it to 0.
